// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry RV32I instruction FIFO feeding a registered decode stage
// with valid/ready on both sides, illegal-opcode detection and synchronous flush.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       op_type,
  output logic [2:0]       op_sub,
  output logic             op_flag,
  output logic [31:0]      imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             use_rs1,
  output logic             use_rs2,
  output logic             write_rd,
  output logic             illegal,
  output logic [PC_W-1:0]  out_pc,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]      instr_q [DEPTH];
  logic [PC_W-1:0]  pc_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             out_valid_q, op_flag_q, use_rs1_q, use_rs2_q, write_rd_q, illegal_q;
  logic [6:0]       op_type_q;
  logic [2:0]       op_sub_q;
  logic [31:0]      imm_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic [PC_W-1:0]  out_pc_q;
  logic             push, load;
  logic [31:0]      i, i_imm, d_imm;
  logic [2:0]       d_sub;
  logic             d_flag, d_u1, d_u2, d_w, d_ill;
  assign in_ready = (count_q < CNT_W'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;
  assign load     = (count_q != '0) && (!out_valid_q || out_ready);
  assign i        = instr_q[rd_ptr_q];
  assign i_imm    = {{20{i[31]}}, i[31:20]};
  always_comb begin
    d_sub  = i[14:12];
    d_imm  = '0;
    d_flag = 1'b0;
    d_u1   = 1'b0;
    d_u2   = 1'b0;
    d_w    = 1'b0;
    d_ill  = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin d_imm = {i[31:12], 12'b0}; d_w = 1'b1; d_sub = 3'b111; end
      7'h6f: begin d_imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; d_w = 1'b1; d_sub = 3'b111; end
      7'h67, 7'h03: begin d_imm = i_imm; d_u1 = 1'b1; d_w = 1'b1; end
      7'h63: begin d_imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; d_u1 = 1'b1; d_u2 = 1'b1; end
      7'h23: begin d_imm = {{20{i[31]}}, i[31:25], i[11:7]}; d_u1 = 1'b1; d_u2 = 1'b1; end
      7'h13: begin
        d_imm  = (i[13:12] == 2'b01) ? {27'b0, i[24:20]} : i_imm;
        d_flag = (i[13:12] == 2'b01) ? i[30] : 1'b0;
        d_u1   = 1'b1;
        d_w    = 1'b1;
      end
      7'h33: begin d_flag = i[30]; d_u1 = 1'b1; d_u2 = 1'b1; d_w = 1'b1; end
      7'h0f: d_imm = {24'b0, i[27:20]};
      default: begin d_ill = 1'b1; d_sub = 3'b111; end
    endcase
    d_w = d_w && (i[11:7] != 5'd0);
  end
  always_ff @(posedge clock)
    if (push) begin
      instr_q[wr_ptr_q] <= in_instr;
      pc_q[wr_ptr_q]    <= in_pc;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      op_type_q   <= '0;
      op_sub_q    <= 3'b111;
      op_flag_q   <= 1'b0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      use_rs1_q   <= 1'b0;
      use_rs2_q   <= 1'b0;
      write_rd_q  <= 1'b0;
      illegal_q   <= 1'b0;
      out_pc_q    <= '0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(load);
      count_q  <= count_q + CNT_W'(push) - CNT_W'(load);
      if (load) begin
        out_valid_q <= 1'b1;
        op_type_q   <= i[6:0];
        op_sub_q    <= d_sub;
        op_flag_q   <= d_flag;
        imm_q       <= d_imm;
        rs1_q       <= i[19:15];
        rs2_q       <= i[24:20];
        rd_q        <= i[11:7];
        use_rs1_q   <= d_u1;
        use_rs2_q   <= d_u2;
        write_rd_q  <= d_w;
        illegal_q   <= d_ill;
        out_pc_q    <= pc_q[rd_ptr_q];
      end else if (out_ready) out_valid_q <= 1'b0;
    end
  assign out_valid = out_valid_q;
  assign op_type   = op_type_q;
  assign op_sub    = op_sub_q;
  assign op_flag   = op_flag_q;
  assign imm       = imm_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign use_rs1   = use_rs1_q;
  assign use_rs2   = use_rs2_q;
  assign write_rd  = write_rd_q;
  assign illegal   = illegal_q;
  assign out_pc    = out_pc_q;
  assign count     = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed checks of decode_queue handshake, backpressure, decode, flush and reset.
module tb_decode_queue;
  logic        clock = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [31:0] in_instr = '0, in_pc = '0, imm, out_pc;
  logic [6:0]  op_type;
  logic [2:0]  op_sub, count;
  logic        op_flag, use_rs1, use_rs2, write_rd, illegal;
  logic [4:0]  rs1, rs2, rd;
  int          checks = 0, errors = 0;

  decode_queue dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_type(op_type), .op_sub(op_sub), .op_flag(op_flag), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .write_rd(write_rd), .illegal(illegal),
    .out_pc(out_pc), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Push one instruction into an idle queue, then wait for it to reach the output stage.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_op_sub", 32'(op_sub), 32'd7);
    chk("rst_imm", imm, 32'd0);
    reset_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // addi x1,x0,5: two edges from accept to out_valid
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    chk("addi_lat1_valid", 32'(out_valid), 32'd0);
    chk("addi_lat1_count", 32'(count), 32'd1);
    step();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_type", 32'(op_type), 32'h13);
    chk("addi_sub", 32'(op_sub), 32'd0);
    chk("addi_imm", imm, 32'd5);
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_flags", {29'd0, write_rd, use_rs1, use_rs2}, 32'b110);
    chk("addi_pc", out_pc, 32'h100);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold_imm", imm, 32'd5);

    issue(32'hFE208EE3, 32'h104);
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_regs", {22'd0, rs1, rs2}, {22'd0, 5'd1, 5'd2});
    chk("beq_flags", {29'd0, write_rd, use_rs1, use_rs2}, 32'b011);
    chk("beq_sub", 32'(op_sub), 32'd0);

    issue(32'h00512423, 32'h108);
    chk("sw_regs", {22'd0, rs1, rs2}, {22'd0, 5'd2, 5'd5});
    chk("sw_imm", imm, 32'd8);
    chk("sw_flags", {29'd0, write_rd, use_rs1, use_rs2}, 32'b011);

    issue(32'h4040D193, 32'h10C);
    chk("srai_imm", imm, 32'd4);
    chk("srai_flag", 32'(op_flag), 32'd1);
    chk("srai_sub", 32'(op_sub), 32'd5);
    chk("srai_rd_rs1", {22'd0, rd, rs1}, {22'd0, 5'd3, 5'd1});

    issue(32'h12345037, 32'h110);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_write_rd", 32'(write_rd), 32'd0);
    chk("lui_sub", 32'(op_sub), 32'd7);

    issue(32'h0000007F, 32'h114);
    chk("ill_illegal", 32'(illegal), 32'd1);
    chk("ill_sub", 32'(op_sub), 32'd7);
    chk("ill_flags", {29'd0, write_rd, use_rs1, use_rs2}, 32'd0);
    chk("ill_imm", imm, 32'd0);
    chk("ill_pc", out_pc, 32'h114);
    step();

    // Fill: 4 FIFO entries plus the output stage under backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fill_ready%0d", k), 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_instr = {12'(k), 20'h00093}; in_pc = 32'h200 + 32'(4 * k);
      step();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_pc", out_pc, 32'h200);
    in_instr = 32'h00F00093; in_pc = 32'h2FC;
    step();
    chk("holdoff_count", 32'(count), 32'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("full_ready_no_comb", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("drain_pc%0d", k), out_pc, 32'h200 + 32'(4 * k));
      chk($sformatf("drain_imm%0d", k), imm, 32'(k));
      step();
    end
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_count", 32'(count), 32'd0);

    // Flush with in_valid high: nothing accepted, everything discarded
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300 + 32'(4 * k);
      step();
    end
    chk("preflush_count", 32'(count), 32'd3);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step();
    chk("postflush_count", 32'(count), 32'd0);
    chk("postflush_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset between clock edges
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_instr = 32'h4040D193; in_pc = 32'h400 + 32'(4 * k);
      step();
    end
    in_valid = 1'b0;
    chk("prerst_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_imm", imm, 32'd0);
    chk("arst_sub", 32'(op_sub), 32'd7);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_flag", 32'(op_flag), 32'd0);
    reset_n = 1'b1;
    step();
    chk("postrst_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, parametrised successor to the single-shot RV32I decoder; sits between instruction fetch and ROB/reservation-station issue.
- Accepts raw instructions with their PC into a DEPTH-entry FIFO using a valid/ready handshake.
- Decodes the FIFO head and presents one registered micro-op per cycle to issue under valid/ready backpressure.
- Adds source/destination-use flags, illegal-opcode detection and a pipeline flush.

Parameters:
- DEPTH, 4, instruction FIFO entries; power of two, 2..16.
- PC_W, 32, width of the PC carried with each instruction.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all queued and output-stage contents.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  FIFO can accept; equals (count < DEPTH) && !flush.
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded micro-op valid.
- out_ready  in  1  issue accepts the micro-op.
- op_type  out  7  instr[6:0].
- op_sub  out  3  funct3; 3'b111 when not applicable.
- op_flag  out  1  instr[30] for OP and for OP-IMM shifts; 0 otherwise.
- imm  out  32  sign-extended immediate per format.
- rs1, rs2, rd  out  5 each  register indices.
- use_rs1, use_rs2, write_rd  out  1 each  operand/destination valid flags.
- illegal  out  1  opcode not recognised.
- out_pc  out  PC_W  PC of the micro-op.
- count  out  CNT_W  FIFO occupancy; excludes the output stage.

Behaviour:
- Reset (async, reset_n=0):
  - FIFO pointers and count go to 0; out_valid=0.
  - All decoded output fields go to 0; op_sub=3'b111.
  - Reset mid-transfer drops everything, with no partial outputs.
- FIFO write: on an edge with in_valid && in_ready, store {in_instr, in_pc} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Output stage load: when the FIFO is non-empty and (!out_valid || out_ready):
  - the decoded head is registered into the output fields;
  - rd_ptr advances and out_valid=1.
- Output stage drain: if out_valid && out_ready and the FIFO is empty, out_valid goes to 0; fields hold their last value.
- Simultaneous write and read: count is unchanged.
- Write into an empty FIFO while the output stage is free: the entry is written this edge and loaded at the next edge. Minimum latency is 2 edges from acceptance to out_valid.
- Full: in_ready=0 whenever count==DEPTH, even if a read occurs in the same cycle. There is no combinational path from out_ready to in_ready.
- Flush has priority over all other events:
  - count=0, pointers=0, out_valid=0;
  - in_ready=0 in the flush cycle, so no accept is possible.
- Decode (combinational on the FIFO head):
  - LUI/AUIPC: imm={i[31:12],12'b0}; rd; write_rd.
  - JAL: imm = J-type sign-extended; write_rd.
  - JALR: I-imm; rs1; op_sub=funct3; write_rd.
  - BRANCH: B-imm {i31×20, i7, i30:25, i11:8, 0}; rs1=i[19:15]; rs2=i[24:20]; both uses set; op_sub=funct3.
  - LOAD: I-imm; rs1; rd; write_rd; op_sub=funct3.
  - STORE: S-imm {i31:25, i11:7} sign-extended; rs1=i[19:15] (base); rs2=i[24:20] (data); both uses set.
  - OP-IMM: funct3 001/101 gives imm={27'b0, i[24:20]} and op_flag=i[30]; other funct3 values give I-imm. use_rs1, write_rd.
  - OP: rs1, rs2, rd, op_flag=i[30]; all three flags set.
  - FENCE: imm={24'b0, i[27:20]}; op_sub=funct3; no register use.
  - Any other opcode: illegal=1, imm=0, all use/write flags 0, op_sub=3'b111.
  - rd==0 forces write_rd=0.
  - Register index fields are always the raw bit slices, regardless of the use flags.

Test Plan:
- Reset, then push addi x1,x0,5 (0x00500093) with pc=0x100 and out_ready=1 → out_valid at the 2nd edge after accept. Expect op_type=0x13, op_sub=0, imm=5, rd=1, write_rd=1, use_rs1=1, use_rs2=0, out_pc=0x100.
- Hold out_ready=0 and push DEPTH+1 instructions → after DEPTH+1 accepts (4 FIFO entries plus the output stage), count=DEPTH and in_ready=0. The next instruction is held off. Release out_ready → in-order drain with no loss or duplication, and the pointers wrap.
- Decode checks:
  - beq x1,x2,-4 (0xFE208EE3) → imm=0xFFFFFFFC, rs1=1, rs2=2, write_rd=0.
  - sw x5,8(x2) (0x00512423) → rs1=2, rs2=5, imm=8.
  - srai x3,x1,4 (0x4040D193) → imm=4, op_flag=1.
- lui x0,0x12345 (0x12345037) → imm=0x12345000, write_rd=0.
- Word 0x0000007F → illegal=1, op_sub=7, all use flags 0.
- Fill 3 entries, then assert flush with in_valid=1 → next cycle count=0 and out_valid=0; the flush-cycle instruction is not accepted. Separately, pulling reset_n low mid-stream clears all outputs asynchronously, with no clock edge required.
